// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-core-side signals of the transmitter arbiter.
// master = arbiter, slave = requesters plus core.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int GID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ack;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_idle;
  logic [GID_W-1:0]        grant_id;
  logic                    busy;
  logic                    err_timeout;

  modport master (
    input  req_valid, req_data, req_last, tx_idle,
    output req_ack, tx_start, tx_data, grant_id, busy, err_timeout
  );

  modport slave (
    output req_valid, req_data, req_last, tx_idle,
    input  req_ack, tx_start, tx_data, grant_id, busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, byte-granular sharing of one uart_tx core between N_REQ sources,
// with frame locking (req_last=0) and ack/lock timeouts.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int ACK_TIMEOUT  = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.master bus
);
  localparam int GID_W = $clog2(N_REQ);
  localparam int ACW   = $clog2(ACK_TIMEOUT + 1);
  localparam int LCW   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ACK  = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] LOCKED    = 2'd3;

  logic [1:0]        state;
  logic [GID_W-1:0]  rr_ptr;
  logic [GID_W-1:0]  gid;
  logic              last_q;
  logic [ACW-1:0]    ack_cnt;
  logic [LCW-1:0]    lock_cnt;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  rot;
  logic              rr_found;
  logic [GID_W-1:0]  rr_win;
  logic              issue;
  logic [GID_W-1:0]  issue_id;
  logic [DATA_W-1:0] issue_data;
  logic [N_REQ-1:0]  issue_oh;

  function automatic logic [GID_W-1:0] wrap_idx(input int v);
    int s;
    s = v;
    if (s >= N_REQ) s = s - N_REQ;
    return GID_W'(s);
  endfunction

  function automatic logic [GID_W-1:0] inc_wrap(input logic [GID_W-1:0] v);
    return (v == GID_W'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // A requester whose ack is in flight has not yet advanced its data: never resample it.
  assign elig = bus.req_valid & ~bus.req_ack;
  assign rot  = N_REQ'({elig, elig} >> rr_ptr);

  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rr_found = 1'b1;
        rr_win   = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  always_comb begin
    issue    = 1'b0;
    issue_id = rr_win;
    if (state == IDLE) begin
      issue = bus.tx_idle & rr_found;
    end else if (state == LOCKED) begin
      issue    = bus.tx_idle & elig[gid];
      issue_id = gid;
    end
  end

  always_comb begin
    issue_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GID_W'(i) == issue_id) issue_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign issue_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << issue_id;
  assign bus.grant_id = gid;
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      gid             <= '0;
      last_q          <= 1'b0;
      ack_cnt         <= '0;
      lock_cnt        <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.req_ack     <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.tx_start    <= 1'b0;
      bus.req_ack     <= '0;
      bus.err_timeout <= 1'b0;
      if (issue) begin
        bus.tx_start <= 1'b1;
        bus.tx_data  <= issue_data;
        bus.req_ack  <= issue_oh;
        gid          <= issue_id;
        last_q       <= bus.req_last[issue_id];
        ack_cnt      <= '0;
        state        <= WAIT_ACK;
      end else begin
        case (state)
          WAIT_ACK: begin
            // The core never went busy: drop the byte and move on without resending.
            if (!bus.tx_idle) begin
              state <= WAIT_DONE;
            end else if (ack_cnt == ACW'(ACK_TIMEOUT - 1)) begin
              bus.err_timeout <= 1'b1;
              rr_ptr          <= inc_wrap(gid);
              state           <= IDLE;
            end else begin
              ack_cnt <= ack_cnt + 1'b1;
            end
          end
          WAIT_DONE: begin
            if (bus.tx_idle) begin
              if (last_q) begin
                rr_ptr <= inc_wrap(gid);
                state  <= IDLE;
              end else begin
                lock_cnt <= '0;
                state    <= LOCKED;
              end
            end
          end
          LOCKED: begin
            if (bus.req_valid[gid]) begin
              lock_cnt <= '0;
            end else if (lock_cnt == LCW'(LOCK_TIMEOUT - 1)) begin
              rr_ptr <= inc_wrap(gid);
              state  <= IDLE;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a uart_tx core model
// advance every negedge; tx_start bytes are checked against an expected queue.
module tb_uart_tx_arbiter;
  localparam int N_REQ        = 4;
  localparam int DATA_W       = 8;
  localparam int ACK_TIMEOUT  = 16;
  localparam int LOCK_TIMEOUT = 64;
  localparam int FRAME        = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W),
    .ACK_TIMEOUT(ACK_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0]        id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t             expq[$];
  exp_t             e;
  logic [DATA_W:0]  rq[N_REQ][$];
  int               checks   = 0;
  int               failures = 0;
  int               core_dly = 0;
  int               core_busy = 0;
  bit               core_hang = 1'b0;
  bit               expect_err = 1'b0;
  logic [N_REQ-1:0] prev_ack = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    logic [N_REQ-1:0]        v;
    logic [N_REQ-1:0]        l;
    logic [N_REQ*DATA_W-1:0] d;
    v = '0;
    l = '0;
    d = bus.req_data;
    for (int i = 0; i < N_REQ; i++) begin
      if (rq[i].size() > 0) begin
        v[i] = 1'b1;
        l[i] = rq[i][0][DATA_W];
        d[i*DATA_W +: DATA_W] = rq[i][0][DATA_W-1:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic push_req(input int i, input logic [DATA_W-1:0] d, input logic last);
    exp_t x;
    rq[i].push_back({last, d});
    x.id   = 2'(i);
    x.data = d;
    expq.push_back(x);
    drive_reqs();
  endtask

  function automatic bit reqs_empty();
    bit r;
    r = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (rq[i].size() > 0) r = 1'b0;
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    if (prev_ack != '0) chk("ack_pulse_width", 32'(bus.req_ack & prev_ack), 32'(0));
    prev_ack = bus.req_ack;
    if (bus.err_timeout && !expect_err) chk("spurious_err_timeout", 32'(1), 32'(0));
    if (bus.tx_start) begin
      if (expq.size() == 0) begin
        chk("unexpected_tx_start", 32'(1), 32'(0));
      end else begin
        e = expq.pop_front();
        chk("tx_data", 32'(bus.tx_data), 32'(e.data));
        chk("grant_id", 32'(bus.grant_id), 32'(e.id));
        chk("req_ack_onehot", 32'(bus.req_ack), 32'(4'b0001 << e.id));
      end
    end
    for (int i = 0; i < N_REQ; i++)
      if (bus.req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive_reqs();
    // uart_tx core model: goes busy 2 cycles after tx_start for FRAME cycles
    if (core_busy > 0) begin
      core_busy--;
      if (core_busy == 0) bus.tx_idle = 1'b1;
    end else if (core_dly > 0) begin
      core_dly--;
      if (core_dly == 0) begin
        bus.tx_idle = 1'b0;
        core_busy   = FRAME;
      end
    end
    if (bus.tx_start && !core_hang) core_dly = 2;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(expq.size() == 0 && reqs_empty() && bus.busy == 1'b0 && bus.tx_idle == 1'b1)
           && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'(1));
  endtask

  initial begin
    int n;
    int bad;
    bus.tx_idle   = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;

    step();
    step();
    chk("rst_tx_start", 32'(bus.tx_start), 32'(0));
    chk("rst_tx_data", 32'(bus.tx_data), 32'(0));
    chk("rst_req_ack", 32'(bus.req_ack), 32'(0));
    chk("rst_grant_id", 32'(bus.grant_id), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_err_timeout", 32'(bus.err_timeout), 32'(0));
    rst = 1'b0;

    // single byte, one-cycle latency, single-cycle ack
    push_req(0, 8'h55, 1'b1);
    step();
    chk("t1_start_latency", 32'(bus.tx_start), 32'(1));
    step();
    chk("t1_ack_cleared", 32'(bus.req_ack), 32'(0));
    chk("t1_start_cleared", 32'(bus.tx_start), 32'(0));
    chk("t1_busy", 32'(bus.busy), 32'(1));
    wait_drain("t1_drain", 400);

    // rr_ptr now 1: req1 must beat req0
    push_req(1, 8'h11, 1'b1);
    push_req(0, 8'h10, 1'b1);
    wait_drain("t1b_rr_ptr_drain", 800);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // round-robin with all four valid
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N_REQ; i++) push_req(i, 8'hA0 + 8'(i), 1'b1);
    wait_drain("t2_rr_drain", 3000);

    // frame lock: req1 three bytes, req0/req2 waiting
    push_req(1, 8'hB1, 1'b0);
    push_req(1, 8'hB2, 1'b0);
    push_req(1, 8'hB3, 1'b1);
    step();
    push_req(2, 8'hC2, 1'b1);
    push_req(0, 8'hC0, 1'b1);
    wait_drain("t3_lock_drain", 2000);

    // lock timeout: req3 locks then goes quiet, req0 waits
    push_req(3, 8'hD3, 1'b0);
    push_req(0, 8'hE0, 1'b1);
    n = 0;
    while (bus.tx_idle && n < 100) begin step(); n++; end
    n = 0;
    while (!bus.tx_idle && n < FRAME + 20) begin step(); n++; end
    chk("t4_frame_end", 32'(bus.tx_idle), 32'(1));
    n = 0;
    while (!bus.tx_start && n < LOCK_TIMEOUT + 50) begin step(); n++; end
    chk("t4_lock_release_latency", 32'(n), 32'(LOCK_TIMEOUT + 2));
    wait_drain("t4_drain", 400);

    // ack timeout: core never leaves idle for req1's byte
    core_hang  = 1'b1;
    expect_err = 1'b1;
    push_req(1, 8'hF1, 1'b1);
    push_req(2, 8'hF2, 1'b1);
    n = 0;
    while (!bus.tx_start && n < 10) begin step(); n++; end
    n = 0;
    while (!bus.err_timeout && n < ACK_TIMEOUT + 20) begin step(); n++; end
    chk("t5_err_latency", 32'(n), 32'(ACK_TIMEOUT));
    chk("t5_busy_at_err", 32'(bus.busy), 32'(0));
    core_hang  = 1'b0;
    expect_err = 1'b0;
    step();
    chk("t5_err_one_cycle", 32'(bus.err_timeout), 32'(0));
    chk("t5_next_served", 32'(bus.tx_start), 32'(1));
    wait_drain("t5_drain", 400);

    // async reset while the core is mid-frame
    push_req(3, 8'h77, 1'b1);
    n = 0;
    while (bus.tx_idle && n < 20) begin step(); n++; end
    chk("t6_in_wait_done", 32'(bus.busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx_start", 32'(bus.tx_start), 32'(0));
    chk("t6_rst_req_ack", 32'(bus.req_ack), 32'(0));
    chk("t6_rst_busy", 32'(bus.busy), 32'(0));
    chk("t6_rst_grant_id", 32'(bus.grant_id), 32'(0));
    chk("t6_rst_tx_data", 32'(bus.tx_data), 32'(0));
    step();
    step();
    rst = 1'b0;
    push_req(1, 8'h88, 1'b1);
    bad = 0;
    n = 0;
    while (!bus.tx_idle && n < FRAME + 20) begin
      step();
      if (bus.tx_start) bad++;
      n++;
    end
    chk("t6_no_issue_while_core_busy", 32'(bad), 32'(0));
    wait_drain("t6_drain", 400);
    chk("expected_queue_empty", 32'(expq.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single UART byte transmitter (tx_start / tx_data / tx_idle core interface) between N_REQ byte sources. Requesters are served round-robin, byte by byte. A requester may lock the transmitter for a multi-byte frame by holding req_last low. The block sits between application logic (LED/status reporters, command responders) and the uart_tx core that drives the serial pin.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
ACK_TIMEOUT, 16, max cycles after tx_start for tx_idle to fall before abort
LOCK_TIMEOUT, 4096, max cycles a locked requester may idle before lock is released

Ports:
clk  input  1  system clock (16 MHz nominal)
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester byte available; data held stable until acked
req_data  input  N_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
req_last  input  N_REQ  byte is last of frame (1 = release after this byte)
req_ack  output  N_REQ  one-cycle pulse: byte taken at the previous edge
tx_start  output  1  one-cycle start pulse to uart_tx core
tx_data  output  DATA_W  byte to core, valid from the tx_start cycle until the next load
tx_idle  input  1  core idle (1 = ready for a new byte)
grant_id  output  clog2(N_REQ)  index of current/last granted requester
busy  output  1  state != IDLE
err_timeout  output  1  one-cycle pulse on ACK_TIMEOUT abort

Behaviour:
- Reset (async, rst=1): state=IDLE, tx_start=0, tx_data=0, req_ack=0, grant_id=0, busy=0, err_timeout=0, rr_ptr=0, lock=0, counters=0.
- States: IDLE, WAIT_ACK, WAIT_DONE, LOCKED.
- IDLE: if tx_idle=1 and any req_valid, winner w = first set bit scanning rr_ptr, rr_ptr+1, ... (mod N_REQ). On the same edge: tx_data<=req_data[w], tx_start<=1, req_ack[w]<=1, grant_id<=w, last_q<=req_last[w]; go WAIT_ACK. If tx_idle=0, do not grant.
- Ack rule: req_ack high for exactly one cycle, the cycle after sampling. The requester advances its data/valid in that cycle. The arbiter never samples the same requester in the cycle req_ack is high.
- WAIT_ACK: tx_start=0 after its single cycle. On tx_idle=0, go WAIT_DONE. If ACK_TIMEOUT cycles (counted from the tx_start cycle) pass with tx_idle=1: err_timeout pulse, lock cleared, rr_ptr=w+1, go IDLE. The byte is considered consumed and is not resent.
- WAIT_DONE: wait for tx_idle=1.
  - last_q=1: rr_ptr<=w+1 mod N_REQ, go IDLE.
  - last_q=0: lock<=1, go LOCKED, lock counter cleared.
- LOCKED: only requester grant_id is eligible. Other req_valid bits are ignored.
  - req_valid[grant_id]=1 and tx_idle=1: issue exactly as from IDLE, go WAIT_ACK.
  - LOCK_TIMEOUT cycles without req_valid[grant_id]: lock<=0, rr_ptr<=grant_id+1, go IDLE.
- Latency: req_valid sampled -> tx_start/req_ack = 1 cycle. Back-to-back bytes are limited by the core's frame time.
- Wrap: rr_ptr and the scan wrap modulo N_REQ. With N_REQ not a power of two, indices >= N_REQ are never produced.
- Simultaneous requests: at most one grant per issue. Lowest index at or after rr_ptr wins.
- Requester drops req_valid without an ack: allowed. No grant occurs, and there is no error.
- Reset mid-transfer: all outputs return to reset values immediately. The core is not aborted; the arbiter re-waits for tx_idle=1 before the next issue.
- tx_start is never asserted while state != IDLE/LOCKED-issue. tx_start is never asserted twice without tx_idle having fallen and risen between, except after a timeout abort.

Test Plan:
- Single byte: req_valid=4'b0001, data 0x55, last=1, core model idle→busy 2 cycles after start for 160 cycles → one tx_start, tx_data=0x55, req_ack[0] pulse 1 cycle after valid, grant_id=0, then IDLE with rr_ptr=1.
- Round-robin: all four valid continuously, last=1, data 0xA0+i → tx_data order 0xA0,0xA1,0xA2,0xA3,0xA0; no requester acked twice before all others are acked.
- Frame lock: req1 sends 3 bytes (last=0,0,1) while req0 and req2 stay valid → tx_data order 3×req1 bytes, then req2, then req0; no interleaving.
- Lock timeout: req3 sends byte with last=0, then drops valid; req0 valid → after LOCK_TIMEOUT cycles req0 is granted and rr_ptr advances past 3.
- Ack timeout: core model holds tx_idle=1 after tx_start → err_timeout pulses at cycle ACK_TIMEOUT, busy=0 next cycle, next requester then served normally.
- Async reset asserted during WAIT_DONE → tx_start, req_ack, busy, grant_id = 0 the same cycle; after release, no issue until tx_idle=1.
